// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the instruction cache line server
// Purpose: refill FSM state encoding and line geometry shared by the cache top and its storage array.
// Ports: none (package).
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2
  } icache_state_t;

  localparam int LINE_WORDS       = 4;
  localparam int WORD_OFFSET_BITS = 4;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage for the direct-mapped instruction cache
// Purpose: per-line valid bit, tag and line data with one combinational read port and one write port.
// Ports:
//   clk, rst                 clock, asynchronous active-high clear of all storage
//   rd_idx_i                 read index; rd_valid_o/rd_tag_o/rd_data_o follow combinationally
//   wr_en_i, wr_idx_i        line write enable and index
//   wr_tag_i, wr_data_i      tag and line data written
//   wr_valid_i               valid bit written with the line
//   inv_all_i                clears every valid bit at the next edge
module icache_array #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 24,
  parameter int LINE_W    = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  input  logic              inv_all_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        tag_q[wr_idx_i]   <= wr_tag_i;
        data_q[wr_idx_i]  <= wr_data_i;
        valid_q[wr_idx_i] <= wr_valid_i;
      end
      // Placed after the write so a coincident invalidate leaves the filled line invalid.
      if (inv_all_i) begin
        valid_q <= '0;
      end
    end
  end

endmodule

// File: rtl/icache_line_server.sv
// rtl/icache_line_server.sv - direct-mapped instruction cache returning a full line per fetch
// Purpose: zero-latency line lookup for the fetch PC; on a miss, refills the line one word per
//          memory beat, then writes it into the array and resumes serving.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   PC_in, rd_en, abort      fetch byte address, fetch request, squash of this cycle's delivery
//   inv_all                  invalidate every line (and any line in flight)
//   D_out, d_out_valid       line at PC_in's index, and strobe when it is a hit for PC_in
//   refill_busy              refill in progress
//   mem_req, mem_addr        word request and byte address toward instruction memory
//   mem_ack, mem_rdata       beat accepted and returned word
module icache_line_server
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int NUM_LINES        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       PC_in,
  input  logic                        rd_en,
  input  logic                        abort,
  input  logic                        inv_all,
  output logic [CACHE_LINE_WIDTH-1:0] D_out,
  output logic                        d_out_valid,
  output logic                        refill_busy,
  output logic                        mem_req,
  output logic [DATA_WIDTH-1:0]       mem_addr,
  input  logic                        mem_ack,
  input  logic [31:0]                 mem_rdata
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LA_W   = DATA_WIDTH - WORD_OFFSET_BITS;
  localparam int TAG_W  = LA_W - IDX_W;
  localparam int BEAT_W = $clog2(LINE_WORDS);

  icache_state_t                         state_q;
  logic [BEAT_W-1:0]                     beat_q;
  logic                                  discard_q;
  logic [LA_W-1:0]                       line_addr_q;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_buf_q;

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic             hit;
  logic             start_refill;
  logic             unused_pc_offset;

  assign pc_idx           = PC_in[WORD_OFFSET_BITS +: IDX_W];
  assign pc_tag           = PC_in[DATA_WIDTH-1 : WORD_OFFSET_BITS+IDX_W];
  assign unused_pc_offset = ^PC_in[WORD_OFFSET_BITS-1:0];

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (CACHE_LINE_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (D_out),
    .wr_en_i    (state_q == FILL),
    .wr_idx_i   (line_addr_q[IDX_W-1:0]),
    .wr_tag_i   (line_addr_q[LA_W-1:IDX_W]),
    .wr_data_i  (line_buf_q),
    .wr_valid_i (~discard_q),
    .inv_all_i  (inv_all)
  );

  // Lookups only count while idle, so a line mid-refill is never reported as a hit.
  assign hit          = rd_en & rd_valid & (rd_tag == pc_tag) & (state_q == IDLE);
  assign d_out_valid  = hit & ~abort;
  assign start_refill = (state_q == IDLE) & rd_en & ~hit & ~abort;

  assign refill_busy = (state_q != IDLE);
  assign mem_req     = (state_q == REFILL);
  assign mem_addr    = mem_req ? {line_addr_q, beat_q, 2'b00} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      discard_q   <= 1'b0;
      line_addr_q <= '0;
      line_buf_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_refill) begin
            line_addr_q <= PC_in[DATA_WIDTH-1:WORD_OFFSET_BITS];
            beat_q      <= '0;
            discard_q   <= 1'b0;
            state_q     <= REFILL;
          end
        end
        REFILL: begin
          // An invalidate during the refill must also kill the line being fetched.
          if (inv_all) begin
            discard_q <= 1'b1;
          end
          if (mem_ack) begin
            line_buf_q[beat_q] <= mem_rdata;
            beat_q             <= beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
              state_q <= FILL;
            end
          end
        end
        FILL: begin
          // The array itself drops the valid bit when inv_all coincides with the write.
          if (inv_all) begin
            discard_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_server.sv
// tb/tb_icache_line_server.sv - directed self-checking bench for icache_line_server
module tb_icache_line_server;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  PC_in = '0;
  logic         rd_en = 1'b0;
  logic         abort = 1'b0;
  logic         inv_all = 1'b0;
  logic [127:0] D_out;
  logic         d_out_valid;
  logic         refill_busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata;

  int checks = 0;
  int errors = 0;
  int ack_period = 1;
  int ack_ctr = 0;

  localparam logic [127:0] L100 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] L200 = 128'hBEEF020C_BEEF0208_BEEF0204_BEEF0200;
  localparam logic [127:0] L300 = 128'hBEEF030C_BEEF0308_BEEF0304_BEEF0300;
  localparam logic [127:0] L400 = 128'hBEEF040C_BEEF0408_BEEF0404_BEEF0400;
  localparam logic [127:0] L600 = 128'hBEEF060C_BEEF0608_BEEF0604_BEEF0600;
  localparam logic [127:0] L700 = 128'hBEEF070C_BEEF0708_BEEF0704_BEEF0700;

  icache_line_server #(
    .DATA_WIDTH       (32),
    .CACHE_LINE_WIDTH (128),
    .NUM_LINES        (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_in       (PC_in),
    .rd_en       (rd_en),
    .abort       (abort),
    .inv_all     (inv_all),
    .D_out       (D_out),
    .d_out_valid (d_out_valid),
    .refill_busy (refill_busy),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: line 0x100 returns 0x11..0x44, every other word is {BEEF, addr[15:0]}.
  assign mem_rdata = (mem_addr[31:4] == 28'h0000010) ? (32'h11 * ({30'd0, mem_addr[3:2]} + 32'd1))
                                                      : {16'hBEEF, mem_addr[15:0]};

  // Acknowledge every ack_period-th cycle of a held request.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_ack = 1'b0;
      ack_ctr = 0;
    end else if (mem_req) begin
      mem_ack = (ack_ctr == ack_period - 1);
      ack_ctr = mem_ack ? 0 : ack_ctr + 1;
    end else begin
      mem_ack = 1'b0;
      ack_ctr = 0;
    end
  end

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      if (!refill_busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: refill_busy=%b required 0 within 100 cycles", name, refill_busy);
    end
  endtask

  task automatic test_reset();
    PC_in = 32'h100; rd_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_req, d_out_valid, refill_busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got req/valid/busy=%b required 000", {mem_req, d_out_valid, refill_busy});
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr);
    end
    checks++;
    if (D_out !== 128'h0) begin
      errors++; $display("FAIL reset_d_out: got %h required 0", D_out);
    end
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_cold_miss();
    @(negedge clk);
    PC_in = 32'h100; rd_en = 1'b1; #1;
    checks++;
    if ({d_out_valid, mem_req, refill_busy} !== 3'b000) begin
      errors++; $display("FAIL cold_c0: got valid/req/busy=%b required 000", {d_out_valid, mem_req, refill_busy});
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * b)) begin
        errors++; $display("FAIL cold_beat%0d: got req=%b addr=%h required 1 %h", b, mem_req, mem_addr, 32'h100 + 32'(4 * b));
      end
      checks++;
      if (d_out_valid !== 1'b0 || refill_busy !== 1'b1) begin
        errors++; $display("FAIL cold_refill_flags%0d: got valid=%b busy=%b required 0 1", b, d_out_valid, refill_busy);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({refill_busy, mem_req, d_out_valid} !== 3'b100) begin
      errors++; $display("FAIL cold_fill: got busy/req/valid=%b required 100", {refill_busy, mem_req, d_out_valid});
    end
    @(negedge clk); #1;
    checks++;
    if (d_out_valid !== 1'b1 || D_out !== L100 || refill_busy !== 1'b0) begin
      errors++; $display("FAIL cold_hit: got valid=%b busy=%b data=%h required 1 0 %h", d_out_valid, refill_busy, D_out, L100);
    end
  endtask

  task automatic test_hit();
    @(negedge clk);
    PC_in = 32'h108; #1;
    checks++;
    if (d_out_valid !== 1'b1 || D_out !== L100 || mem_req !== 1'b0) begin
      errors++; $display("FAIL hit_same_line: got valid=%b req=%b data=%h required 1 0 %h", d_out_valid, mem_req, D_out, L100);
    end
    @(negedge clk);
    PC_in = 32'h10C; #1;
    checks++;
    if (d_out_valid !== 1'b1 || mem_req !== 1'b0 || refill_busy !== 1'b0) begin
      errors++; $display("FAIL hit_next: got valid=%b req=%b busy=%b required 1 0 0", d_out_valid, mem_req, refill_busy);
    end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    PC_in = 32'h200; #1;
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL conflict_miss200: got valid=%b required 0", d_out_valid);
    end
    wait_idle("conflict200");
    checks++;
    if (d_out_valid !== 1'b1 || D_out !== L200) begin
      errors++; $display("FAIL conflict_hit200: got valid=%b data=%h required 1 %h", d_out_valid, D_out, L200);
    end
    PC_in = 32'h100; #1;
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL conflict_evicted100: got valid=%b required 0", d_out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL conflict_refill100: got req=%b addr=%h required 1 00000100", mem_req, mem_addr);
    end
    wait_idle("conflict100");
  endtask

  task automatic test_stall();
    ack_period = 3;
    @(negedge clk);
    PC_in = 32'h400; #1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h400 + 32'(4 * ((c - 1) / 3))) begin
        errors++; $display("FAIL stall_c%0d: got req=%b addr=%h required 1 %h", c, mem_req, mem_addr, 32'h400 + 32'(4 * ((c - 1) / 3)));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (d_out_valid !== 1'b0 || refill_busy !== 1'b1) begin
      errors++; $display("FAIL stall_fill: got valid=%b busy=%b required 0 1", d_out_valid, refill_busy);
    end
    @(negedge clk); #1;
    checks++;
    if (d_out_valid !== 1'b1 || D_out !== L400) begin
      errors++; $display("FAIL stall_hit: got valid=%b data=%h required 1 %h", d_out_valid, D_out, L400);
    end
    ack_period = 1;
  endtask

  task automatic test_redirect();
    @(negedge clk);
    PC_in = 32'h100; #1;
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_miss: got valid=%b required 0", d_out_valid);
    end
    @(negedge clk);
    PC_in = 32'h300;
    for (int b = 0; b < 4; b++) begin
      if (b != 0) @(negedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * b)) begin
        errors++; $display("FAIL redir_beat%0d: got req=%b addr=%h required 1 %h", b, mem_req, mem_addr, 32'h100 + 32'(4 * b));
      end
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (d_out_valid !== 1'b0 || refill_busy !== 1'b0 || D_out !== L100) begin
      errors++; $display("FAIL redir_after_fill: got valid=%b busy=%b data=%h required 0 0 %h", d_out_valid, refill_busy, D_out, L100);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
      errors++; $display("FAIL redir_new_miss: got req=%b addr=%h required 1 00000300", mem_req, mem_addr);
    end
    wait_idle("redir300");
    checks++;
    if (d_out_valid !== 1'b1 || D_out !== L300) begin
      errors++; $display("FAIL redir_hit300: got valid=%b data=%h required 1 %h", d_out_valid, D_out, L300);
    end
  endtask

  task automatic test_no_request();
    @(negedge clk);
    PC_in = 32'h500; rd_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin rd_en = 1'b1; abort = 1'b1; end
      #1;
      checks++;
      if ({mem_req, refill_busy, d_out_valid} !== 3'b000) begin
        errors++; $display("FAIL noreq_c%0d: got req/busy/valid=%b required 000", i, {mem_req, refill_busy, d_out_valid});
      end
      @(negedge clk);
    end
    PC_in = 32'h300; #1;
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_hit: got valid=%b required 0", d_out_valid);
    end
    abort = 1'b0; #1;
    checks++;
    if (d_out_valid !== 1'b1) begin
      errors++; $display("FAIL unabort_hit: got valid=%b required 1", d_out_valid);
    end
  endtask

  task automatic test_inv_all();
    @(negedge clk);
    PC_in = 32'h600; #1;
    @(negedge clk);
    @(negedge clk);
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    wait_idle("inv600");
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL inv_refill_discard: got valid=%b required 0", d_out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
      errors++; $display("FAIL inv_rerequest: got req=%b addr=%h required 1 00000600", mem_req, mem_addr);
    end
    wait_idle("inv600b");
    checks++;
    if (d_out_valid !== 1'b1 || D_out !== L600) begin
      errors++; $display("FAIL inv_refilled: got valid=%b data=%h required 1 %h", d_out_valid, D_out, L600);
    end
    // inv_all coinciding with the FILL cycle
    @(negedge clk);
    PC_in = 32'h700; #1;
    repeat (5) @(negedge clk);
    inv_all = 1'b1; #1;
    checks++;
    if (refill_busy !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL inv_fill_state: got busy=%b req=%b required 1 0", refill_busy, mem_req);
    end
    @(negedge clk);
    inv_all = 1'b0; #1;
    checks++;
    if (d_out_valid !== 1'b0 || refill_busy !== 1'b0 || D_out !== L700) begin
      errors++; $display("FAIL inv_fill_wins: got valid=%b busy=%b data=%h required 0 0 %h", d_out_valid, refill_busy, D_out, L700);
    end
    wait_idle("inv700");
    checks++;
    if (d_out_valid !== 1'b1) begin
      errors++; $display("FAIL inv700_hit: got valid=%b required 1", d_out_valid);
    end
    // inv_all while idle drops the hit on the next cycle
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0; rd_en = 1'b0; #1;
    rd_en = 1'b1; #1;
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL inv_idle: got valid=%b required 0", d_out_valid);
    end
    wait_idle("inv700b");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    PC_in = 32'h100; #1;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got req=%b required 1", mem_req);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, refill_busy, d_out_valid} !== 3'b000 || mem_addr !== 32'h0 || D_out !== 128'h0) begin
      errors++; $display("FAIL areset_now: got req/busy/valid=%b addr=%h data=%h required 000 0 0", {mem_req, refill_busy, d_out_valid}, mem_addr, D_out);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_miss: got valid=%b required 0", d_out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL areset_refill: got req=%b addr=%h required 1 00000100", mem_req, mem_addr);
    end
    wait_idle("areset");
    checks++;
    if (d_out_valid !== 1'b1 || D_out !== L100) begin
      errors++; $display("FAIL areset_hit: got valid=%b data=%h required 1 %h", d_out_valid, D_out, L100);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_stall();
    test_redirect();
    test_no_request();
    test_inv_all();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_line_server.md
# icache_line_server

Direct-mapped instruction cache that serves the fetch side of the instruction fetch queue. Each cycle it looks up the line addressed by the fetch PC and returns a full 128-bit line, four 32-bit instructions, with a valid strobe. On a miss it refills the line from a 32-bit word-wide memory port and then resumes serving. It sits between the fetch PC/IFQ and the instruction memory.

## Interface
Parameters:
- DATA_WIDTH, 32, address and instruction width
- CACHE_LINE_WIDTH, 128, line width (4 words)
- NUM_LINES, 16, number of lines; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- PC_in  in  DATA_WIDTH  fetch byte address; bits [3:0] ignored
- rd_en  in  1  fetch request (IFQ not full)
- abort  in  1  squash this cycle's delivery
- inv_all  in  1  invalidate all lines
- D_out  out  CACHE_LINE_WIDTH  line data; word k on [32k+31:32k]
- d_out_valid  out  1  D_out is the line for PC_in
- refill_busy  out  1  refill FSM not IDLE
- mem_req  out  1  memory beat request
- mem_addr  out  DATA_WIDTH  byte address of requested word
- mem_ack  in  1  beat accepted; mem_rdata valid
- mem_rdata  in  32  returned word

## Operation
- IDX = $clog2(NUM_LINES). index = PC_in[4+IDX-1:4]; tag = PC_in[DATA_WIDTH-1:4+IDX].
- Arrays: valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES]. Read is combinational; write is on the clock edge.
- hit = rd_en & valid[index] & (tag[index]==tag) & state==IDLE.
- d_out_valid = hit & ~abort. D_out = data[index], whether or not the lookup hits.
- FSM states: IDLE, REFILL, FILL.
  - IDLE: if rd_en & ~hit & ~abort, latch line_addr = PC_in[DATA_WIDTH-1:4], set beat=0, clear discard, and go to REFILL.
  - REFILL:
    - mem_req=1; mem_addr = {line_addr, beat[1:0], 2'b00}.
    - On mem_ack: buf[beat] <= mem_rdata and beat++.
    - On the ack for beat 3, go to FILL.
  - FILL: data[idx(line_addr)] <= buf; tag <= tag(line_addr); valid <= ~discard. Then go to IDLE.
- mem_req=0 and mem_addr=0 outside REFILL. mem_ack outside REFILL is ignored.
- A refill is never cancelled once started.
  - PC_in changing (jump/branch) during REFILL/FILL has no effect on the refill.
  - The new PC is looked up on return to IDLE.
- inv_all:
  - Clears every valid bit at the next edge.
  - If asserted in REFILL/FILL, it sets discard, so the in-flight line is written with valid=0.
  - If inv_all and a FILL with discard=0 coincide, inv_all wins: the line ends invalid.
- abort suppresses d_out_valid and blocks starting a refill that cycle.

## Timing
- Hit latency: 0 cycles. d_out_valid and D_out are combinational from PC_in in the same cycle.
- Miss with mem_ack every cycle:
  - Miss detected in cycle 0.
  - REFILL in cycles 1–4.
  - FILL in cycle 5.
  - Hit in cycle 6.
- Each idle cycle without mem_ack extends REFILL by one. mem_req and mem_addr stay stable while unacknowledged.
- d_out_valid=0 throughout REFILL and FILL. refill_busy=1 in REFILL and FILL.
- Reset values:
  - state IDLE, beat 0, discard 0.
  - All valid bits 0; tag and data arrays 0.
  - mem_req 0, mem_addr 0, d_out_valid 0, D_out 0, refill_busy 0.
- Reset mid-refill aborts the refill immediately. No line is written and the arrays are cleared.

## Structure
- Shared package icache_pkg holds:
  - typedef enum {IDLE, REFILL, FILL} icache_state_t
  - LINE_WORDS=4 and WORD_OFFSET_BITS=4
- Sub-module icache_array holds the valid/tag/data storage. It provides:
  - A combinational read port.
  - One write port.
  - A synchronous inv_all clear, plus asynchronous clear on rst.
- The top level holds the FSM, beat counter, refill buffer and hit logic.

## Test plan
- Cold miss: reset, then rd_en=1 with PC_in=0x100; memory returns 0x11, 0x22, 0x33, 0x44 with ack every cycle.
  - mem_addr sequence is 0x100, 0x104, 0x108, 0x10C.
  - In cycle 6, d_out_valid=1 and D_out={0x44,0x33,0x22,0x11}.
- Hit: then PC_in=0x108 (same line) → d_out_valid=1 in the same cycle with the same D_out, and mem_req stays 0.
- Conflict eviction: fill 0x100, then fill 0x200 (both index 0), then request 0x100 → miss, and a refill starts at mem_addr 0x100.
- Stalled memory: ack only every third cycle → mem_req and mem_addr are held per beat, and the hit arrives 2 cycles after the 4th ack.
- Redirect and abort:
  - PC_in changes to 0x300 during refill of 0x100 → the 0x100 refill completes, then a new miss is issued for 0x300.
  - rd_en=0 or abort=1 on a miss → no mem_req.
- inv_all during REFILL → after FILL, re-request of the same PC misses.
- Asynchronous rst mid-refill → all outputs are 0 immediately, and the next request misses.
